// File: rtl/turf_event_header_reader.sv
//-----------------------------------------------------------------------------
// turf_event_header_reader
//
// Consumer side of the TURF event header RAM. Completed buffer numbers are
// queued in order of completion; for each one the 22 header words are read
// from the RAM one at a time and presented on a valid/ready stream. Once the
// final word of a header is accepted, a one-cycle release pulse frees that
// buffer back to the hold logic.
//
// Ports:
//   clk33_i           readout clock (event RAM read port lives here)
//   rst_n_i           asynchronous active-low reset
//   event_done_i      one-cycle pulse: header for event_buffer_i is complete
//   event_buffer_i    buffer number of the completed header
//   ram_addr_o        event RAM read address {buffer, word}
//   ram_rd_o          RAM read enable (data returns one cycle later)
//   ram_dat_i         RAM read data
//   hdr_dat_o         header word to the readout path
//   hdr_valid_o       hdr_dat_o is valid
//   hdr_ready_i       downstream accepts a word on valid && ready
//   hdr_last_o        final word of the header is being presented
//   hdr_buffer_o      buffer currently being streamed
//   release_o         one-cycle pulse after the last word is accepted
//   release_buffer_o  buffer being released (valid with release_o)
//   pending_o         pending-buffer queue occupancy
//   overflow_o        sticky: a completion was dropped on a full queue
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module turf_event_header_reader #(
  parameter int HEADER_WORDS = 22,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        event_done_i,
  input  logic [1:0]  event_buffer_i,
  output logic [7:0]  ram_addr_o,
  output logic        ram_rd_o,
  input  logic [15:0] ram_dat_i,
  output logic [15:0] hdr_dat_o,
  output logic        hdr_valid_o,
  input  logic        hdr_ready_i,
  output logic        hdr_last_o,
  output logic [1:0]  hdr_buffer_o,
  output logic        release_o,
  output logic [1:0]  release_buffer_o,
  output logic [2:0]  pending_o,
  output logic        overflow_o
);

  localparam int          PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [2:0]  DEPTH_CNT = 3'(QUEUE_DEPTH);
  localparam logic [5:0]  LAST_WORD = 6'(HEADER_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PRESENT,
    S_RELEASE
  } state_t;

  state_t           state;
  logic [1:0]       cur_buf;
  logic [5:0]       word_cnt;

  logic [1:0]       q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] q_wr_ptr;
  logic [PTR_W-1:0] q_rd_ptr;
  logic [2:0]       q_count;
  logic [1:0]       q_head;
  logic             q_empty;
  logic             q_full;
  logic             q_push;
  logic             q_pop;
  logic             q_drop;

  // Circular pointer advance; handles depths that are not a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QUEUE_DEPTH - 1))
      return '0;
    else
      return p + 1'b1;
  endfunction

  assign q_empty = (q_count == 3'd0);
  assign q_full  = (q_count == DEPTH_CNT);
  assign q_head  = q_mem[q_rd_ptr];

  // The queue pops exactly when the FSM leaves IDLE. A pop in the same cycle
  // frees a slot, so a completion arriving on a full queue is still accepted.
  assign q_pop   = (state == S_IDLE) && !q_empty;
  assign q_push  = event_done_i && (!q_full || q_pop);
  assign q_drop  = event_done_i && q_full && !q_pop;

  // Queue storage carries no reset: occupancy and pointers define validity.
  // At full, the write slot equals the slot being popped; the pop reads the
  // old entry before this edge overwrites it, so ordering is preserved.
  always_ff @(posedge clk33_i) begin
    if (q_push)
      q_mem[q_wr_ptr] <= event_buffer_i;
  end

  // Queue control
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_wr_ptr   <= '0;
      q_rd_ptr   <= '0;
      q_count    <= 3'd0;
      overflow_o <= 1'b0;
    end else begin
      if (q_push)
        q_wr_ptr <= ptr_next(q_wr_ptr);
      if (q_pop)
        q_rd_ptr <= ptr_next(q_rd_ptr);
      case ({q_push, q_pop})
        2'b10:   q_count <= q_count + 3'd1;
        2'b01:   q_count <= q_count - 3'd1;
        default: q_count <= q_count;
      endcase
      if (q_drop)
        overflow_o <= 1'b1;
    end
  end

  // Header read FSM. The RAM strobe/address are set on the edge entering
  // FETCH and cleared on the edge leaving it, so they are high only in FETCH.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      cur_buf     <= 2'd0;
      word_cnt    <= 6'd0;
      ram_rd_o    <= 1'b0;
      ram_addr_o  <= 8'd0;
      hdr_dat_o   <= 16'd0;
      hdr_valid_o <= 1'b0;
      release_o   <= 1'b0;
    end else begin
      case (state)
        // IDLE -> FETCH: take the oldest completed buffer
        S_IDLE: begin
          if (!q_empty) begin
            cur_buf    <= q_head;
            word_cnt   <= 6'd0;
            ram_rd_o   <= 1'b1;
            ram_addr_o <= {q_head, 6'd0};
            state      <= S_FETCH;
          end
        end
        // FETCH -> LATCH: read issued, data returns next cycle
        S_FETCH: begin
          ram_rd_o   <= 1'b0;
          ram_addr_o <= 8'd0;
          state      <= S_LATCH;
        end
        // LATCH -> PRESENT: capture RAM data into the output register
        S_LATCH: begin
          hdr_dat_o   <= ram_dat_i;
          hdr_valid_o <= 1'b1;
          state       <= S_PRESENT;
        end
        // PRESENT: hold word until accepted (valid is always high here)
        S_PRESENT: begin
          if (hdr_ready_i) begin
            hdr_valid_o <= 1'b0;
            if (word_cnt == LAST_WORD) begin
              release_o <= 1'b1;
              state     <= S_RELEASE;
            end else begin
              word_cnt   <= word_cnt + 6'd1;
              ram_rd_o   <= 1'b1;
              ram_addr_o <= {cur_buf, 6'(word_cnt + 6'd1)};
              state      <= S_FETCH;
            end
          end
        end
        // RELEASE -> IDLE: single-cycle release pulse
        S_RELEASE: begin
          release_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          ram_rd_o    <= 1'b0;
          ram_addr_o  <= 8'd0;
          hdr_valid_o <= 1'b0;
          release_o   <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign hdr_last_o       = hdr_valid_o && (word_cnt == LAST_WORD);
  assign hdr_buffer_o     = cur_buf;
  assign release_buffer_o = cur_buf;
  assign pending_o        = q_count;

endmodule
